// File: rtl/alu_pkg.sv
// alu_pkg: opcode codes, set-cc bit index and condition-code flag type for sparc_alu_32bit
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int S_BIT = 4;
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_AND  = 6'b000001;
  localparam logic [5:0] OP_OR   = 6'b000010;
  localparam logic [5:0] OP_XOR  = 6'b000011;
  localparam logic [5:0] OP_SUB  = 6'b000100;
  localparam logic [5:0] OP_ANDN = 6'b000101;
  localparam logic [5:0] OP_ORN  = 6'b000110;
  localparam logic [5:0] OP_XNOR = 6'b000111;
  localparam logic [5:0] OP_ADDX = 6'b001000;
  localparam logic [5:0] OP_SUBX = 6'b001100;
  localparam logic [5:0] OP_SLL  = 6'b100101;
  localparam logic [5:0] OP_SRL  = 6'b100110;
  localparam logic [5:0] OP_SRA  = 6'b100111;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
endpackage

// File: rtl/sparc_alu_32bit_if.sv
// sparc_alu_32bit_if: operand, opcode, result and condition-code bundle of the ALU
interface sparc_alu_32bit_if;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [5:0]  opcode;
  logic        carry;
  logic [31:0] result;
  logic        N;
  logic        Z;
  logic        C;
  logic        V;
  modport master (output A_in, B_in, opcode, carry, input result, N, Z, C, V);
  modport slave  (input A_in, B_in, opcode, carry, output result, N, Z, C, V);
endinterface

// File: rtl/alu_cc_reg.sv
// alu_cc_reg: condition-code register with load enable and asynchronous active-low clear
module alu_cc_reg
  import alu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  flags_t flags_in,
  output flags_t flags_q
);
  flags_t flags_d;
  // next flags: take new codes only when a cc operation loads them
  always_comb flags_d = load ? flags_in : flags_q;
  // flag storage, cleared immediately while rst_n is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flags_q <= '0;
    else flags_q <= flags_d;
endmodule

// File: rtl/sparc_alu_32bit.sv
// sparc_alu_32bit: 32-bit combinational ALU with registered N/Z/C/V condition codes
// Build option ALU_INTERNAL_CARRY_EN: ADDX/SUBX use the registered C flag instead of the carry port.
module sparc_alu_32bit
  import alu_pkg::*;
(
  input logic clk,
  input logic rst_n,
  sparc_alu_32bit_if.slave bus
);
  flags_t flags_q;
  flags_t flags_new;
  logic [WIDTH-1:0] a, b, res;
  logic [WIDTH:0] sum;
  logic [5:0] code;
  logic cin, c, v, arith_logic;
  assign a = bus.A_in;
  assign b = bus.B_in;
  assign code = {bus.opcode[5], 1'b0, bus.opcode[3:0]};
`ifdef ALU_INTERNAL_CARRY_EN
  assign cin = flags_q.c;
`else
  assign cin = bus.carry;
`endif
  // decode the base code into a result plus carry/overflow for flag-updating ops
  always_comb begin
    sum = '0;
    res = '0;
    c = 1'b0;
    v = 1'b0;
    arith_logic = 1'b1;
    case (code)
      OP_ADD, OP_ADDX: begin
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin & (code == OP_ADDX)};
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SUBX: begin
        sum = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin & (code == OP_SUBX)};
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_ANDN: res = a & ~b;
      OP_ORN:  res = a | ~b;
      OP_XNOR: res = ~(a ^ b);
      OP_SLL: begin
        res = a << b[4:0];
        arith_logic = 1'b0;
      end
      OP_SRL: begin
        res = a >> b[4:0];
        arith_logic = 1'b0;
      end
      OP_SRA: begin
        res = $signed(a) >>> b[4:0];
        arith_logic = 1'b0;
      end
      default: arith_logic = 1'b0;
    endcase
  end
  assign flags_new = '{n: res[WIDTH-1], z: (res == '0), c: c, v: v};
  alu_cc_reg u_cc (
    .clk(clk),
    .rst_n(rst_n),
    .load(bus.opcode[S_BIT] & arith_logic),
    .flags_in(flags_new),
    .flags_q(flags_q)
  );
  assign bus.result = res;
  assign bus.N = flags_q.n;
  assign bus.Z = flags_q.z;
  assign bus.C = flags_q.c;
  assign bus.V = flags_q.v;
endmodule

// File: tb/tb_sparc_alu_32bit.sv
// tb_sparc_alu_32bit: directed-vector self-checking bench for sparc_alu_32bit
module tb_sparc_alu_32bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  sparc_alu_32bit_if bus();
  sparc_alu_32bit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic [31:0] exp_r, input logic [3:0] exp_f);
    @(negedge clk);
    bus.opcode = op;
    bus.A_in = a;
    bus.B_in = b;
    bus.carry = cin;
    #1 chk({tag, ".result"}, bus.result, exp_r);
    @(posedge clk);
    #1 chk({tag, ".nzcv"}, {28'b0, bus.N, bus.Z, bus.C, bus.V}, {28'b0, exp_f});
  endtask
  initial begin
    bus.opcode = 6'b000000;
    bus.A_in = 32'h0;
    bus.B_in = 32'h0;
    bus.carry = 1'b0;
    #1 chk("reset.nzcv", {28'b0, bus.N, bus.Z, bus.C, bus.V}, 32'h0);
    @(posedge clk);
    #1 chk("reset_hold.nzcv", {28'b0, bus.N, bus.Z, bus.C, bus.V}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("addcc_wrap", 6'b010000, 32'hffffffff, 32'h00000001, 1'b0, 32'h00000000, 4'b0110);
    step("add_nocc",   6'b000000, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0110);
    step("andcc",      6'b010001, 32'h11110000, 32'h11111111, 1'b0, 32'h11110000, 4'b0000);
    step("and_nocc",   6'b000001, 32'h00000000, 32'h11111111, 1'b0, 32'h00000000, 4'b0000);
    step("subcc",      6'b010100, 32'h01000001, 32'hf0000001, 1'b0, 32'h11000000, 4'b0010);
    step("subxcc_c0",  6'b011100, 32'hefffffff, 32'hffffffff, 1'b0, 32'hf0000000, 4'b1010);
    step("subxcc_c1",  6'b011100, 32'h00000005, 32'h00000003, 1'b1, 32'h00000001, 4'b0000);
    step("addcc_c",    6'b010000, 32'hffffffff, 32'h00000001, 1'b0, 32'h00000000, 4'b0110);
    step("addxcc_ovf", 6'b011000, 32'h7fffffff, 32'h00000000, 1'b1, 32'h80000000, 4'b1001);
    step("sll",        6'b100101, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b1001);
    step("srl",        6'b100110, 32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b1001);
    step("sra",        6'b100111, 32'h80000000, 32'h00000004, 1'b0, 32'hf8000000, 4'b1001);
    step("sll_zero",   6'b100101, 32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 4'b1001);
    step("srl_31",     6'b100110, 32'h80000000, 32'h0000001f, 1'b0, 32'h00000001, 4'b1001);
    step("andncc",     6'b010101, 32'h00000000, 32'h11111111, 1'b0, 32'h00000000, 4'b0100);
    step("orcc",       6'b010010, 32'h80000000, 32'h00000001, 1'b0, 32'h80000001, 4'b1000);
    step("xorcc",      6'b010011, 32'h000000ff, 32'h0000000f, 1'b0, 32'h000000f0, 4'b0000);
    step("orncc",      6'b010110, 32'h00000000, 32'hffffffff, 1'b0, 32'h00000000, 4'b0100);
    step("subcc_eq",   6'b010100, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b0100);
    step("xnorcc",     6'b010111, 32'h00000000, 32'h11111111, 1'b0, 32'heeeeeeee, 4'b1000);
    #2 rst_n = 1'b0;
    #1 chk("async_rst.nzcv", {28'b0, bus.N, bus.Z, bus.C, bus.V}, 32'h0);
    #1 rst_n = 1'b1;
    step("xnorcc2",    6'b010111, 32'h00000000, 32'h11111111, 1'b0, 32'heeeeeeee, 4'b1000);
    step("undef",      6'b111111, 32'hffffffff, 32'h00000001, 1'b0, 32'h00000000, 4'b1000);
    step("undef_s",    6'b011001, 32'hffffffff, 32'h00000001, 1'b1, 32'h00000000, 4'b1000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
